d_ip_reg_master: RTL and testbench

Register-bus initiator for the d_ip peripheral register interface (addr/wr_en/mod_en/wdata/rdata), i.e. the requester side that peripherals such as d_ip_timer respond to. It accepts read/write commands over a valid/ready stream into a small command FIFO, then sequences each command as one bus access. For reads it returns the captured rdata on a valid/ready response stream. It is the single driver of the register bus between a control source (CPU shim, test sequencer) and one peripheral.

---
 rtl/d_ip_reg_master.sv | 180 ++++++++++++++++++
 tb/tb_d_ip_reg_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_ip_reg_master.sv
// d_ip_reg_master: register-bus initiator for the d_ip peripheral interface.
// Commands arrive on a valid/ready stream into a small FIFO; each one becomes
// a single registered bus access. Read data is captured RD_LAT cycles after
// the access and returned on a one-deep valid/ready response stream.
module d_ip_reg_master #(
  parameter int AW     = 6,
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1,
  parameter int GAP    = 0
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic [AW-1:0] addr,
  output logic          wr_en,
  output logic          mod_en,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 1 + AW + DW;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);
  localparam logic [1:0]    LAT_LAST = 2'(RD_LAT);
  localparam logic [1:0]    GAP_LAST = 2'(GAP);

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, GAPW} state_t;

  // Command storage: {write, addr, wdata} per entry.
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          ready_en_reg;
  logic          full, empty, push, pop;

  logic          head_write;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;

  state_t        state_reg, state_next;
  logic [1:0]    cnt_reg, cnt_next;
  logic          sample;
  logic          rsp_free;
  logic          mod_en_next, wr_en_next;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] wdata_next;

  assign full      = (count_reg == FULL_CNT);
  assign empty     = (count_reg == '0);
  // ready_en_reg keeps cmd_ready low while reset is held and until the first edge after release.
  assign cmd_ready = ready_en_reg && !full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = !empty || (state_reg != IDLE);
  // A new access may start only if any response it could produce has room.
  assign rsp_free  = !rsp_valid || rsp_ready;

  assign {head_write, head_addr, head_wdata} = mem[rd_ptr_reg];

  // Command FIFO storage; the bus registers below act as its read register.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + ONE_CNT;
        2'b01:   count_reg <= count_reg - ONE_CNT;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sequencer state register with its shared latency/gap counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic plus next values of the registered bus outputs.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pop         = 1'b0;
    sample      = 1'b0;
    mod_en_next = 1'b0;
    wr_en_next  = 1'b0;
    addr_next   = addr;
    wdata_next  = wdata;
    unique case (state_reg)
      IDLE: begin
        if (!empty && rsp_free) begin
          pop         = 1'b1;
          mod_en_next = 1'b1;
          wr_en_next  = head_write;
          addr_next   = head_addr;
          wdata_next  = head_wdata;
          state_next  = ACCESS;
        end
      end
      ACCESS: begin
        // wr_en still holds the direction of the access being driven.
        cnt_next = 2'd1;
        if (!wr_en)       state_next = RWAIT;
        else if (GAP > 0) state_next = GAPW;
        else              state_next = IDLE;
      end
      RWAIT: begin
        if (cnt_reg == LAT_LAST) begin
          sample     = 1'b1;
          cnt_next   = 2'd1;
          state_next = (GAP > 0) ? GAPW : IDLE;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      GAPW: begin
        if (cnt_reg == GAP_LAST) state_next = IDLE;
        else                     cnt_next   = cnt_reg + 2'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered bus outputs; addr and wdata hold between accesses.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mod_en <= 1'b0;
      wr_en  <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
    end else begin
      mod_en <= mod_en_next;
      wr_en  <= wr_en_next;
      addr   <= addr_next;
      wdata  <= wdata_next;
    end
  end

  // Response slot: loads on the read sample edge, otherwise drains on rsp_ready.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (sample) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= rdata;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_d_ip_reg_master.sv
// tb_d_ip_reg_master: two initiators (GAP=0/RD_LAT=1 and GAP=2/RD_LAT=2) share
// one command stream; each talks to its own register-file responder and is
// compared every cycle against a timestamp-based transaction model.
module tb_d_ip_reg_master;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NI    = 2;
  localparam int NLIT  = 6;
  localparam logic [7:0] LIT [NLIT] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h5A, 8'hC3};

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          cmd_valid [NI] = '{default: 1'b0};
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_ready = 1'b1;

  logic          dut_cmd_ready [NI];
  logic          dut_rsp_valid [NI];
  logic [DW-1:0] dut_rsp_rdata [NI];
  logic          dut_busy      [NI];
  logic [AW-1:0] dut_addr      [NI];
  logic          dut_wr_en     [NI];
  logic          dut_mod_en    [NI];
  logic [DW-1:0] dut_wdata     [NI];
  logic [DW-1:0] dut_rdata     [NI] = '{default: '0};

  always #5 clk = ~clk;

  function automatic int gap_of(input int i);
    return 2 * i;
  endfunction

  function automatic int lat_of(input int i);
    return i + 1;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    d_ip_reg_master #(
      .AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(gi + 1), .GAP(2 * gi)
    ) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .cmd_valid (cmd_valid[gi]),
      .cmd_ready (dut_cmd_ready[gi]),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (dut_rsp_valid[gi]),
      .rsp_ready (rsp_ready),
      .rsp_rdata (dut_rsp_rdata[gi]),
      .busy      (dut_busy[gi]),
      .addr      (dut_addr[gi]),
      .wr_en     (dut_wr_en[gi]),
      .mod_en    (dut_mod_en[gi]),
      .wdata     (dut_wdata[gi]),
      .rdata     (dut_rdata[gi])
    );
  end

  // Register-file responder: writes land during the access cycle; read data
  // appears in the RD_LAT-th cycle after the access, random data otherwise.
  int            rcnt = 0;
  int            due [NI] = '{default: -1};
  logic [AW-1:0] due_addr [NI] = '{default: '0};
  logic [DW-1:0] regs [NI][64] = '{default: '{default: '0}};

  always @(negedge clk) begin
    rcnt++;
    for (int i = 0; i < NI; i++) begin
      if (dut_mod_en[i] && dut_wr_en[i]) regs[i][dut_addr[i]] = dut_wdata[i];
      if (dut_mod_en[i] && !dut_wr_en[i]) begin
        due[i]      = rcnt + lat_of(i);
        due_addr[i] = dut_addr[i];
      end
      dut_rdata[i] = (rcnt == due[i]) ? regs[i][due_addr[i]] : DW'($urandom);
    end
  end

  // Transaction model: a command queue plus "engine idle from edge N" and
  // "capture rdata at edge N" timestamps per initiator.
  cmd_t          mq [NI][$];
  int            cyc = 0;
  int            idle_from   [NI] = '{default: 0};
  int            sample_edge [NI] = '{default: -1};
  int            loads       [NI] = '{default: 0};
  logic          e_ready [NI] = '{default: 1'b0};
  logic          e_busy  [NI] = '{default: 1'b0};
  logic          e_mod   [NI] = '{default: 1'b0};
  logic          e_wr    [NI] = '{default: 1'b0};
  logic          e_rv    [NI] = '{default: 1'b0};
  logic [AW-1:0] e_addr  [NI] = '{default: '0};
  logic [DW-1:0] e_wdata [NI] = '{default: '0};
  logic [DW-1:0] e_rd    [NI] = '{default: '0};

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NI; i++) begin
        mq[i].delete();
        idle_from[i]   = 0;
        sample_edge[i] = -1;
        e_ready[i] = 1'b0; e_busy[i] = 1'b0; e_mod[i] = 1'b0; e_wr[i] = 1'b0;
        e_rv[i] = 1'b0; e_addr[i] = '0; e_wdata[i] = '0; e_rd[i] = '0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        logic rfree;
        cmd_t c;
        rfree = !e_rv[i] || rsp_ready;
        if (sample_edge[i] == cyc) begin
          e_rv[i] = 1'b1;
          e_rd[i] = dut_rdata[i];
          loads[i]++;
          sample_edge[i] = -1;
        end else if (rsp_ready) begin
          e_rv[i] = 1'b0;
        end
        e_mod[i] = 1'b0;
        e_wr[i]  = 1'b0;
        if (mq[i].size() > 0 && cyc > idle_from[i] && rfree) begin
          c = mq[i].pop_front();
          e_mod[i]   = 1'b1;
          e_wr[i]    = c.w;
          e_addr[i]  = c.a;
          e_wdata[i] = c.d;
          if (c.w) begin
            idle_from[i] = cyc + 1 + gap_of(i);
          end else begin
            sample_edge[i] = cyc + 1 + lat_of(i);
            idle_from[i]   = cyc + 1 + lat_of(i) + gap_of(i);
          end
        end
        if (cmd_valid[i] && e_ready[i]) mq[i].push_back(cmd_t'({cmd_write, cmd_addr, cmd_wdata}));
        e_ready[i] = (mq[i].size() < DEPTH);
        e_busy[i]  = (mq[i].size() > 0) || (cyc < idle_from[i]);
      end
    end
  end

  // Compare process: every output of every initiator on every falling edge.
  int checks = 0;
  int failures = 0;
  bit fin_req = 1'b0;
  bit fin_seen = 1'b0;
  bit stalled = 1'b0;
  int ncmd = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("cmd_ready", i, 32'(dut_cmd_ready[i]), 32'(e_ready[i]));
      chk("busy",      i, 32'(dut_busy[i]),      32'(e_busy[i]));
      chk("mod_en",    i, 32'(dut_mod_en[i]),    32'(e_mod[i]));
      chk("wr_en",     i, 32'(dut_wr_en[i]),     32'(e_wr[i]));
      chk("addr",      i, 32'(dut_addr[i]),      32'(e_addr[i]));
      chk("wdata",     i, 32'(dut_wdata[i]),     32'(e_wdata[i]));
      chk("rsp_valid", i, 32'(dut_rsp_valid[i]), 32'(e_rv[i]));
      chk("rsp_rdata", i, 32'(dut_rsp_rdata[i]), 32'(e_rd[i]));
      if (e_rv[i] && loads[i] >= 1 && loads[i] <= NLIT)
        chk("rsp_literal", i, 32'(dut_rsp_rdata[i]), 32'(LIT[loads[i] - 1]));
    end
    if (fin_req && !fin_seen) begin
      fin_seen = 1'b1;
      chk("no_stall", 0, 32'(stalled), 32'd0);
      for (int i = 0; i < NI; i++) begin
        chk("drained_busy", i, 32'(dut_busy[i]), 32'd0);
        chk("literal_count", i, 32'(loads[i] >= NLIT), 32'd1);
      end
    end
  end

  // Present one command to both initiators until each has accepted it.
  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit [NI-1:0] acc;
    int n;
    acc = '0;
    n = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    ncmd++;
    $display("cmd %0d %s addr=%02h wdata=%02h", ncmd, w ? "WR" : "RD", a, d);
    while (!(&acc) && n < 300) begin
      for (int i = 0; i < NI; i++) begin
        cmd_valid[i] = !acc[i];
        if (!acc[i] && dut_cmd_ready[i]) acc[i] = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < NI; i++) cmd_valid[i] = 1'b0;
    if (n >= 300) stalled = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      for (int i = 0; i < NI; i++) cmd_valid[i] = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      @(negedge clk);
    end
  endtask

  bit rnd_done = 1'b0;

  initial begin
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    idle(2);

    // single write then read back; write/read of 0x3C
    send(1'b1, 6'h05, 8'hA5); idle(8);
    send(1'b0, 6'h05, 8'h00); idle(10);
    send(1'b1, 6'h12, 8'h3C);
    send(1'b0, 6'h12, 8'h00); idle(12);

    // burst of four writes on consecutive cycles
    for (int k = 0; k < 4; k++) send(1'b1, AW'(8'h30 + k), DW'($urandom));
    idle(20);

    // read held by response back-pressure, queued write behind it
    rsp_ready = 1'b0;
    send(1'b0, 6'h05, 8'h00);
    send(1'b1, 6'h07, 8'h11);
    idle(10);
    rsp_ready = 1'b1;
    idle(12);

    // fill the FIFO behind an unaccepted response; fifth push waits
    rsp_ready = 1'b0;
    send(1'b0, 6'h12, 8'h00);
    fork
      begin
        for (int k = 0; k < 5; k++) send(1'b1, AW'(8'h20 + k), DW'($urandom));
      end
      begin
        repeat (20) @(negedge clk);
        rsp_ready = 1'b1;
      end
    join
    idle(15);

    // timer compare registers, reset during the read wait, then read back
    send(1'b1, 6'h02, 8'h5A);
    send(1'b1, 6'h03, 8'hC3);
    idle(12);
    send(1'b0, 6'h02, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2 rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    idle(2);
    send(1'b0, 6'h02, 8'h00);
    send(1'b0, 6'h03, 8'h00);
    idle(15);

    // randomized traffic with random response back-pressure
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          send(1'($urandom), AW'($urandom), DW'($urandom));
          idle($urandom_range(0, 2));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    idle(60);

    fin_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
